// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants and types for the digital clock design.
//   CLK_HZ                  : system clock frequency in Hz
//   DEB_CYCLES_DEF          : default debounce window (10 ms)
//   REPEAT_DELAY_DEF        : default press-to-first-repeat delay (0.5 s)
//   REPEAT_PERIOD_DEF       : default repeat interval (0.1 s)
//   rpt_state_t             : per-channel auto-repeat FSM state
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int CLK_HZ            = 50_000_000;
    localparam int DEB_CYCLES_DEF    = CLK_HZ / 100;
    localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEF = CLK_HZ / 10;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: two-flop synchroniser, debounce counter, registered
// press/release strobes and (with BUTTON_AUTO_REPEAT_EN defined) an
// auto-repeat FSM that re-fires btn_press while the button is held.
//
// Ports:
//   clk         in  system clock
//   clr         in  asynchronous active-high reset
//   btn_raw     in  raw contact input (asynchronous, active-high)
//   btn_level   out debounced level
//   btn_press   out one-cycle strobe on accepted press (and on repeats)
//   btn_release out one-cycle strobe on accepted release
//   btn_held    out high while in the auto-repeat phase (0 if feature off)
//
// Build option: BUTTON_AUTO_REPEAT_EN enables the auto-repeat FSM.
// -----------------------------------------------------------------------------
module btn_debounce_ch
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_held
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          rise_evt;
    logic          fall_evt;
    logic          rpt_pulse;

    // A new level is accepted once s2 has disagreed with the stable level
    // for DEB_CYCLES consecutive cycles; any agreement restarts the count.
    assign accept   = (s2 != stable) && (cnt == DEB_LAST);
    assign rise_evt = accept &  s2;
    assign fall_evt = accept & ~s2;

    // Synchroniser, debounce counter and output strobe registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            stable      <= 1'b0;
            cnt         <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            btn_press   <= rise_evt | rpt_pulse;
            btn_release <= fall_evt;
        end
    end

    assign btn_level = stable;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_t    state;
    rpt_state_t    state_n;
    logic [RW-1:0] rc;
    logic [RW-1:0] rc_n;

    // Repeat FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= RPT_IDLE;
            rc    <= '0;
        end else begin
            state <= state_n;
            rc    <= rc_n;
        end
    end

    // A release always wins: it returns to idle and suppresses any repeat
    // strobe that would have landed on the same cycle.
    always_comb begin
        state_n   = state;
        rc_n      = rc;
        rpt_pulse = 1'b0;
        if (fall_evt) begin
            state_n = RPT_IDLE;
            rc_n    = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (rise_evt) begin
                        state_n = RPT_DELAY;
                        rc_n    = '0;
                    end
                end
                RPT_DELAY: begin
                    if (rc == RD_LAST) begin
                        rpt_pulse = 1'b1;
                        state_n   = RPT_REPEAT;
                        rc_n      = '0;
                    end else begin
                        rc_n = rc + RW'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (rc == RP_LAST) begin
                        rpt_pulse = 1'b1;
                        rc_n      = '0;
                    end else begin
                        rc_n = rc + RW'(1);
                    end
                end
                default: begin
                    state_n = RPT_IDLE;
                    rc_n    = '0;
                end
            endcase
        end
    end

    assign btn_held = (state == RPT_REPEAT);
`else
    assign rpt_pulse = 1'b0;
    assign btn_held  = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions N_BTN raw button/switch lines into clean clk-domain levels and
// single-cycle press/release strobes. Channels are fully independent.
//
// Ports:
//   clk         in  system clock
//   clr         in  asynchronous active-high reset
//   btn_raw     in  [N_BTN] raw contact inputs, active-high
//   btn_level   out [N_BTN] debounced levels
//   btn_press   out [N_BTN] press strobes (plus auto-repeats when enabled)
//   btn_release out [N_BTN] release strobes
//   btn_held    out [N_BTN] auto-repeat phase indicator (0 if feature off)
//
// Build option: BUTTON_AUTO_REPEAT_EN enables per-channel auto-repeat.
// -----------------------------------------------------------------------------
module button_conditioner
    import clock_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_held
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .clr         (clr),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_held    (btn_held[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_held;

    int nvec = 0;
    int nmis = 0;

    button_conditioner #(
        .N_BTN         (N),
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_held    (btn_held)
    );

    always #5 clk = ~clk;

    // Behavioural model: a level flips once the last DEB raw samples, seen
    // through the two-cycle synchroniser delay, all disagree with it.
    // Repeats are timed from the edge on which the level rose.
    typedef struct packed {
        logic         level;
        logic         press;
        logic         rel;
        logic         held;
        int           k;
        logic [DEB:0] samp;
    } mst_t;

    mst_t mdl [N];

    function automatic mst_t model_step(input mst_t s, input logic raw);
        mst_t n;
        logic flip;
        n     = s;
        flip  = 1'b1;
        for (int j = 1; j <= DEB; j++)
            if (s.samp[j] == s.level) flip = 1'b0;
        n.press = 1'b0;
        n.rel   = 1'b0;
        if (flip) begin
            n.level = ~s.level;
            if (n.level) begin
                n.press = 1'b1;
                n.k     = 0;
            end else begin
                n.rel = 1'b1;
            end
        end else if (s.level) begin
            n.k = s.k + 1;
            if (RPT && (n.k == RD || (n.k > RD && ((n.k - RD) % RP) == 0)))
                n.press = 1'b1;
        end
        n.held = RPT && n.level && (n.k >= RD);
        n.samp = {s.samp[DEB-1:0], raw};
        return n;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int c = 0; c < N; c++) mdl[c] <= '0;
        end else begin
            for (int c = 0; c < N; c++) mdl[c] <= model_step(mdl[c], btn_raw[c]);
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] el, ep, er, eh;
        for (int c = 0; c < N; c++) begin
            el[c] = mdl[c].level;
            ep[c] = mdl[c].press;
            er[c] = mdl[c].rel;
            eh[c] = mdl[c].held;
        end
        chk("model_level",   btn_level,   el);
        chk("model_press",   btn_press,   ep);
        chk("model_release", btn_release, er);
        chk("model_held",    btn_held,    eh);
    endtask

    // One clock edge, then check outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        int cp, cr, cg, ca;
        bit fell;

        // Reset with all buttons held
        @(negedge clk);
        btn_raw = 4'b1111;
        repeat (3) step();
        chk("rst_level",   btn_level,   4'b0000);
        chk("rst_press",   btn_press,   4'b0000);
        chk("rst_release", btn_release, 4'b0000);
        chk("rst_held",    btn_held,    4'b0000);
        clr = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) chk("rst_lvl_e5", btn_level, 4'b0000);
            if (e == 6) begin
                chk("rst_lvl_e6",   btn_level, 4'b1111);
                chk("rst_press_e6", btn_press, 4'b1111);
            end
            if (e == 7) chk("rst_press_e7", btn_press, 4'b0000);
        end
        btn_raw = '0;
        repeat (12) step();

        // Clean press/release on ch0
        btn_raw = 4'b0001;
        cp = 0; cr = 0;
        for (int e = 1; e <= 32; e++) begin
            if (e == 21) btn_raw = 4'b0000;
            step();
            cp += int'(btn_press[0]);
            cr += int'(btn_release[0]);
            if (e == 6) begin
                chk("ch0_lvl_e6",   {3'b0, btn_level[0]}, 4'b0001);
                chk("ch0_press_e6", {3'b0, btn_press[0]}, 4'b0001);
            end
            if (e == 25) chk("ch0_lvl_e25", {3'b0, btn_level[0]}, 4'b0001);
            if (e == 26) begin
                chk("ch0_lvl_e26", {3'b0, btn_level[0]},   4'b0000);
                chk("ch0_rel_e26", {3'b0, btn_release[0]}, 4'b0001);
            end
        end
        chk("ch0_press_cnt", 4'(cp), RPT ? 4'd3 : 4'd1);
        chk("ch0_rel_cnt",   4'(cr), 4'd1);

        // Bounce on ch1: 1,0,1,0,1 then held
        for (int e = 1; e <= 14; e++) begin
            logic [4:0] pat;
            pat = 5'b10101;
            btn_raw[1] = (e <= 5) ? pat[e-1] : 1'b1;
            step();
            if (e < 10) chk("bounce_quiet", {btn_level[1], btn_press[1], 2'b0}, 4'b0000);
            if (e == 10) chk("bounce_press", {3'b0, btn_press[1]}, 4'b0001);
        end
        btn_raw = '0;
        repeat (12) step();

        // Glitch on ch2: three cycles only
        cg = 0;
        for (int e = 1; e <= 15; e++) begin
            btn_raw[2] = (e <= 3);
            step();
            cg += int'(btn_level[2] | btn_press[2] | btn_release[2]);
        end
        chk("glitch_activity", 4'(cg), 4'd0);

        // Auto-repeat on ch3
        btn_raw = 4'b1000;
        repeat (6) step();
        chk("rpt_press_k0", {3'b0, btn_press[3]}, 4'b0001);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("rpt_press_k", {3'b0, btn_press[3]},
                (RPT && (k inside {10, 15, 20, 25, 30, 35, 40})) ? 4'b0001 : 4'b0000);
            if (k == 9)  chk("rpt_held_k9",  {3'b0, btn_held[3]}, 4'b0000);
            if (k == 10) chk("rpt_held_k10", {3'b0, btn_held[3]}, RPT ? 4'b0001 : 4'b0000);
        end
        btn_raw = '0;
        fell = 1'b0; ca = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (fell) ca += int'(btn_press[3]);
            if (!btn_level[3]) fell = 1'b1;
        end
        chk("rpt_after_rel_press", 4'(ca), 4'd0);
        chk("rpt_after_rel_held",  btn_held, 4'b0000);

        // Simultaneous ch0 + ch1
        btn_raw = 4'b0011;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) chk("sim_press_e5", btn_press, 4'b0000);
            if (e == 6) chk("sim_press_e6", btn_press, 4'b0011);
        end
        cp = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            cp += int'(btn_press[0]);
            if (k == 10) chk("sim_held_k10", btn_held, RPT ? 4'b0011 : 4'b0000);
            if (k == 12) chk("sim_press_k12", btn_press, 4'b0000);
        end
        chk("sim_rpt_cnt", 4'(cp), RPT ? 4'd5 : 4'd0);
        btn_raw = '0;
        repeat (12) step();
        chk("final_level", btn_level, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
